// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = X - Y - BorrowIn, one bit per clock, LSB first.
// A start/busy/done handshake wraps a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             SubStart,
  input  logic [WIDTH-1:0] SubX,
  input  logic [WIDTH-1:0] SubY,
  input  logic             SubBorrowIn,
  output logic             SubBusy,
  output logic             SubDone,
  output logic [WIDTH-1:0] SubDiff,
  output logic             SubBorrowOut,
  output logic             SubOverflow
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  x_sr;
  logic [WIDTH-1:0]  y_sr;
  logic [WIDTH-1:0]  res_sr;
  logic              borrow;
  logic [CntW-1:0]   cnt;
  logic              x_msb;
  logic              y_msb;

  logic              bit_x;
  logic              bit_y;
  logic              bit_d;
  logic              bit_b;
  logic [WIDTH-1:0]  res_next;

  // Full-subtractor cell working on the current LSBs and the stored borrow.
  assign bit_x    = x_sr[0];
  assign bit_y    = y_sr[0];
  assign bit_d    = bit_x ^ bit_y ^ borrow;
  assign bit_b    = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & borrow);
  assign res_next = {bit_d, res_sr[WIDTH-1:1]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      x_sr         <= '0;
      y_sr         <= '0;
      res_sr       <= '0;
      borrow       <= 1'b0;
      cnt          <= '0;
      x_msb        <= 1'b0;
      y_msb        <= 1'b0;
      SubBusy      <= 1'b0;
      SubDone      <= 1'b0;
      SubDiff      <= '0;
      SubBorrowOut <= 1'b0;
      SubOverflow  <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request just like IDLE, giving back-to-back operation.
        IDLE, DONE: begin
          SubDone <= 1'b0;
          if (SubStart) begin
            x_sr    <= SubX;
            y_sr    <= SubY;
            x_msb   <= SubX[WIDTH-1];
            y_msb   <= SubY[WIDTH-1];
            res_sr  <= '0;
            borrow  <= SubBorrowIn;
            cnt     <= '0;
            SubBusy <= 1'b1;
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          res_sr <= res_next;
          borrow <= bit_b;
          cnt    <= cnt + 1'b1;
          // The last bit's sign decides overflow against the latched operand signs.
          if (cnt == LastBit) begin
            SubBusy      <= 1'b0;
            SubDone      <= 1'b1;
            SubDiff      <= res_next;
            SubBorrowOut <= bit_b;
            SubOverflow  <= (x_msb != y_msb) && (bit_d != x_msb);
            state        <= DONE;
          end
        end
        default: begin
          SubBusy <= 1'b0;
          SubDone <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=4 and WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;

  logic       start4, bin4, busy4, done4, bout4, ovf4;
  logic [3:0] x4, y4, diff4;

  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] x8, y8, diff8;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(reset), .SubStart(start4), .SubX(x4), .SubY(y4),
    .SubBorrowIn(bin4), .SubBusy(busy4), .SubDone(done4), .SubDiff(diff4),
    .SubBorrowOut(bout4), .SubOverflow(ovf4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(reset), .SubStart(start8), .SubX(x8), .SubY(y8),
    .SubBorrowIn(bin8), .SubBusy(busy8), .SubDone(done8), .SubDiff(diff8),
    .SubBorrowOut(bout8), .SubOverflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits at a falling edge; returns at the falling edge of the accept cycle.
  task automatic pulse_start4(input logic [3:0] x, input logic [3:0] y, input logic b);
    start4 = 1'b1; x4 = x; y4 = y; bin4 = b;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic pulse_start8(input logic [7:0] x, input logic [7:0] y, input logic b);
    start8 = 1'b1; x8 = x; y8 = y; bin8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts cycles until done; a stuck design returns the bound value.
  task automatic wait_done4(output int lat);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start4 = 1'b0; x4 = '0; y4 = '0; bin4 = 1'b0;
    start8 = 1'b0; x8 = '0; y8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy4, done4, diff4, bout4, ovf4} !== 8'h00) begin
      errors++;
      $display("FAIL reset4: got %b expected 00000000", {busy4, done4, diff4, bout4, ovf4});
    end
    checks++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset8: got %b expected 000000000000", {busy8, done8, diff8, bout8, ovf8});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    pulse_start4(4'd9, 4'd3, 1'b0);
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b expected 1", busy4);
    end
    wait_done4(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    // 9 is -7 signed; -7 - 3 = -10 does not fit in 4 bits.
    checks++;
    if ({diff4, bout4, ovf4} !== {4'h6, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_result: got diff=%h bout=%b ovf=%b expected diff=6 bout=0 ovf=1",
               diff4, bout4, ovf4);
    end
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [3:0] tx   [4] = '{4'h3, 4'h7, 4'h8, 4'h0};
    logic [3:0] ty   [4] = '{4'h9, 4'h8, 4'h1, 4'h0};
    logic       tb_in[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] ed   [4] = '{4'hA, 4'hF, 4'h7, 4'h0};
    logic       eb   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       eo   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      pulse_start4(tx[i], ty[i], tb_in[i]);
      wait_done4(lat);
      checks++;
      if ({diff4, bout4, ovf4} !== {ed[i], eb[i], eo[i]} || lat !== 4) begin
        errors++;
        $display("FAIL directed%0d: got diff=%h bout=%b ovf=%b lat=%0d expected diff=%h bout=%b ovf=%b lat=4",
                 i, diff4, bout4, ovf4, lat, ed[i], eb[i], eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    int lat;
    pulse_start4(4'd5, 4'd5, 1'b1);
    @(negedge clk);
    start4 = 1'b1; x4 = 4'd2; y4 = 4'd1; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL ignored_latency: got %0d expected 2", lat);
    end
    checks++;
    if ({diff4, bout4, ovf4} !== {4'hF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL equal_borrow: got diff=%h bout=%b ovf=%b expected diff=f bout=1 ovf=0",
               diff4, bout4, ovf4);
    end
    @(negedge clk);
    checks++;
    if ({busy4, done4, diff4, bout4} !== {1'b0, 1'b0, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL not_queued: got busy=%b done=%b diff=%h bout=%b expected busy=0 done=0 diff=f bout=1",
               busy4, done4, diff4, bout4);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    pulse_start4(4'd9, 4'd3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy4, done4, diff4, bout4, ovf4} !== 8'h00) begin
      errors++;
      $display("FAIL abort_clear: got %b expected 00000000", {busy4, done4, diff4, bout4, ovf4});
    end
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    pulse_start4(4'd9, 4'd3, 1'b0);
    wait_done4(lat);
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: got %b expected 1", done4);
    end
    start4 = 1'b1; x4 = 4'd3; y4 = 4'd9; bin4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if ({busy4, done4} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy4, done4);
    end
    wait_done4(lat);
    checks++;
    if ({diff4, bout4, ovf4} !== {4'hA, 1'b1, 1'b1} || lat !== 4) begin
      errors++;
      $display("FAIL b2b_result: got diff=%h bout=%b ovf=%b lat=%0d expected diff=a bout=1 ovf=1 lat=4",
               diff4, bout4, ovf4, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_width8;
    int lat;
    pulse_start8(8'd200, 8'd55, 1'b0);
    wait_done8(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL w8_latency: got %0d expected 8", lat);
    end
    // 200 is -56 signed; -56 - 55 = -111 still fits in 8 bits.
    checks++;
    if ({diff8, bout8, ovf8} !== {8'd145, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL w8_result: got diff=%0d bout=%b ovf=%b expected diff=145 bout=0 ovf=0",
               diff8, bout8, ovf8);
    end
    @(negedge clk);
  endtask

  task automatic test_random8;
    logic [7:0] x, y, ediff;
    logic       b, eb, eo;
    int         sres, lat;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      b = 1'($urandom_range(0, 1));
      ediff = 8'(int'(x) - int'(y) - int'(b));
      eb    = (int'(x) < int'(y) + int'(b));
      sres  = int'($signed(x)) - int'($signed(y)) - int'(b);
      eo    = (sres < -128) || (sres > 127);
      pulse_start8(x, y, b);
      wait_done8(lat);
      checks++;
      if ({diff8, bout8, ovf8} !== {ediff, eb, eo} || lat !== 8) begin
        errors++;
        $display("FAIL random%0d x=%0d y=%0d b=%b: got diff=%0d bout=%b ovf=%b lat=%0d expected diff=%0d bout=%b ovf=%b lat=8",
                 i, x, y, b, diff8, bout8, ovf8, lat, ediff, eb, eo);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_directed;
    test_ignored_start;
    test_reset_abort;
    test_back_to_back;
    test_width8;
    test_random8;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
